objects_mux_prio: RTL and testbench
===================================

# objects_mux_prio

Parametrised successor to the single-object pixel mux. It selects the output pixel colour from NUM_LAYERS drawing objects plus a background, using fixed index priority and colour-key transparency. It also detects per-pixel overlap between layer 0 (the ball) and every other layer, and latches those collisions per frame for the game-logic block. It sits between the object drawers and the VGA output stage, with a fixed 2-cycle pipeline.

## Interface
- NUM_LAYERS, 4, number of object layers (≥2); index 0 has the highest priority.
- RGB_W, 8, pixel colour width.
- TRANSPARENT_COLOR, 8'hFF (RGB_W bits), colour key; a layer pixel equal to it is treated as not drawing.
- IDX_W, $clog2(NUM_LAYERS), layer index width (derived, not overridden).

Ports:
- clk  in  1  pixel clock; single clock domain.
- resetN  in  1  asynchronous active-low reset.
- startOfFrame  in  1  one-cycle pulse, coincident with the first pixel of a frame.
- drawingRequest  in  NUM_LAYERS  per-layer draw request for the current pixel.
- layerRGB  in  NUM_LAYERS*RGB_W  packed colours; layer k occupies bits [k*RGB_W +: RGB_W].
- layerEnable  in  NUM_LAYERS  static per-layer mask; 0 disables the layer entirely.
- backGroundRGB  in  RGB_W  colour used when no layer is qualified.
- RGBOut  out  RGB_W  selected pixel colour, registered.
- activeLayer  out  IDX_W  index of the layer shown in RGBOut; 0 when activeValid=0.
- activeValid  out  1  1 when RGBOut comes from a layer, 0 when it is background.
- collisionHit  out  NUM_LAYERS  per-pixel overlap pulse, aligned with RGBOut; bit 0 is always 0.
- frameCollision  out  NUM_LAYERS  sticky collisions of the previous frame; bit 0 is always 0.

## Operation
- Qualification, combinational at input: q[k] = drawingRequest[k] & layerEnable[k] & (layerRGB[k] != TRANSPARENT_COLOR).
- Stage 1 registers: q vector, all layerRGB, backGroundRGB, and overlap ov[k] = q[0] & q[k] for k≥1 (ov[0]=0).
- Stage 2 registers:
  - Find the lowest k with s1_q[k]=1.
  - RGBOut = s1_RGB[k], activeLayer = k, activeValid = 1.
  - If no layer is qualified: RGBOut = s1_backGround, activeLayer = 0, activeValid = 0.
  - collisionHit = s1_ov.
- Accumulator acc[NUM_LAYERS-1:0]:
  - Every cycle: acc <= acc | s1_ov.
  - Cycle with startOfFrame=1: frameCollision <= acc | s1_ov and acc <= 0. Clear wins over the set.
  - The pixel presented with startOfFrame enters stage 1 one cycle later, so it is counted in the new frame. Pixels already in stage 1 count in the old frame.
- frameCollision holds its value for a full frame and changes only on startOfFrame.
- layerEnable is sampled every cycle. Changing it mid-frame takes effect on the next pixel, with no glitch beyond that pixel's own pipeline.
- An all-zero drawingRequest passes background through with normal latency.

## Timing
- Reset, asynchronous with resetN=0: all pipeline registers, RGBOut, activeLayer, activeValid, collisionHit, acc and frameCollision go to 0 immediately.
- Reset mid-frame discards in-flight pixels and accumulated collisions. The first valid output appears 2 cycles after the first post-reset input edge.
- Latency: inputs at edge n appear on RGBOut, activeLayer, activeValid and collisionHit after edge n+2. Throughput is 1 pixel per clock, with no stalls.
- frameCollision updates at the edge that samples startOfFrame=1. That is a latency of 1 from the pulse, independent of the pixel pipeline.
- Simultaneous events:
  - Several layers qualified: the lowest index wins.
  - Layer 0 overlapping several layers: several collisionHit bits assert in the same cycle.
  - startOfFrame on consecutive cycles: each pulse publishes and clears; the second publishes only the overlap of the pixel in stage 1.
- No combinational path from input to output.

## Test plan
- Reset: hold resetN=0 with random inputs, then release. RGBOut=0, activeValid=0 and frameCollision=0 until the 2nd edge after release.
- Priority:
  - drawingRequest=4'b0110, layerRGB = {8'h40, 8'h30, 8'h20, 8'h10}, background 8'h05 → 2 cycles later RGBOut=8'h20, activeLayer=1, activeValid=1.
  - Request 0 → RGBOut=8'h05, activeValid=0.
- Transparency and enable:
  - Layer 1 colour 8'hFF with request set, layer 2 = 8'h30 → RGBOut=8'h30, activeLayer=2.
  - layerEnable=4'b1011 with the same stimulus → layer 2 skipped, layer 3 shown (8'h40).
- Collision pulse: drawingRequest=4'b1001 for 3 pixels → collisionHit=4'b1000 for exactly those 3 output cycles, 2 cycles delayed. RGBOut shows the layer 0 colour.
- Frame latch:
  - Overlap of layers 0/2 in frame A, startOfFrame → frameCollision=4'b0100 one cycle after the pulse, held through frame B with no overlaps.
  - Next startOfFrame → frameCollision=0.
- Boundary: overlap of layers 0/1 presented in the cycle before startOfFrame → counted in the old frame (frameCollision[1]=1). The same overlap presented with startOfFrame → counted only at the following frame's publish.

Source files
------------

// File: rtl/objects_mux_prio.sv
// Priority pixel mux over NUM_LAYERS objects plus background, with colour-key transparency,
// ball-vs-layer overlap detection and a per-frame sticky collision latch. Fixed 2-cycle pipeline.
module objects_mux_prio #(
  parameter int unsigned       NUM_LAYERS        = 4,
  parameter int unsigned       RGB_W             = 8,
  parameter logic [RGB_W-1:0]  TRANSPARENT_COLOR = {RGB_W{1'b1}},
  localparam int unsigned      IDX_W             = $clog2(NUM_LAYERS)
) (
  input  logic                        clk,
  input  logic                        resetN,
  input  logic                        startOfFrame,
  input  logic [NUM_LAYERS-1:0]       drawingRequest,
  input  logic [NUM_LAYERS*RGB_W-1:0] layerRGB,
  input  logic [NUM_LAYERS-1:0]       layerEnable,
  input  logic [RGB_W-1:0]            backGroundRGB,
  output logic [RGB_W-1:0]            RGBOut,
  output logic [IDX_W-1:0]            activeLayer,
  output logic                        activeValid,
  output logic [NUM_LAYERS-1:0]       collisionHit,
  output logic [NUM_LAYERS-1:0]       frameCollision
);

  logic [NUM_LAYERS-1:0]       w_q;
  logic [NUM_LAYERS-1:0]       w_ov;
  logic [NUM_LAYERS-1:0]       r_s1_q;
  logic [NUM_LAYERS-1:0]       r_s1_ov;
  logic [NUM_LAYERS*RGB_W-1:0] r_s1_rgb;
  logic [RGB_W-1:0]            r_s1_bg;

  logic [RGB_W-1:0]            w_sel_rgb;
  logic [IDX_W-1:0]            w_sel_idx;
  logic                        w_sel_vld;

  logic [RGB_W-1:0]            r_rgb;
  logic [IDX_W-1:0]            r_idx;
  logic                        r_vld;
  logic [NUM_LAYERS-1:0]       r_hit;
  logic [NUM_LAYERS-1:0]       r_acc;
  logic [NUM_LAYERS-1:0]       r_frame;

  // Qualification and ball overlap at the input, before any register.
  always_comb begin
    w_q  = '0;
    w_ov = '0;
    for (int k = 0; k < NUM_LAYERS; k++) begin
      w_q[k] = drawingRequest[k] & layerEnable[k] &
               (layerRGB[k*RGB_W +: RGB_W] != TRANSPARENT_COLOR);
    end
    for (int k = 1; k < NUM_LAYERS; k++) begin
      w_ov[k] = w_q[0] & w_q[k];
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_s1_q   <= '0;
      r_s1_ov  <= '0;
      r_s1_rgb <= '0;
      r_s1_bg  <= '0;
    end else begin
      r_s1_q   <= w_q;
      r_s1_ov  <= w_ov;
      r_s1_rgb <= layerRGB;
      r_s1_bg  <= backGroundRGB;
    end
  end

  // Scan from the top down so the lowest qualified index is the last to assign.
  always_comb begin
    w_sel_rgb = r_s1_bg;
    w_sel_idx = '0;
    w_sel_vld = 1'b0;
    for (int k = NUM_LAYERS - 1; k >= 0; k--) begin
      if (r_s1_q[k]) begin
        w_sel_rgb = r_s1_rgb[k*RGB_W +: RGB_W];
        w_sel_idx = IDX_W'(k);
        w_sel_vld = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_rgb <= '0;
      r_idx <= '0;
      r_vld <= 1'b0;
      r_hit <= '0;
    end else begin
      r_rgb <= w_sel_rgb;
      r_idx <= w_sel_idx;
      r_vld <= w_sel_vld;
      r_hit <= r_s1_ov;
    end
  end

  // The stage-1 pixel at the frame edge still belongs to the frame being published.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_acc   <= '0;
      r_frame <= '0;
    end else if (startOfFrame) begin
      r_frame <= r_acc | r_s1_ov;
      r_acc   <= '0;
    end else begin
      r_acc   <= r_acc | r_s1_ov;
    end
  end

  assign RGBOut         = r_rgb;
  assign activeLayer    = r_idx;
  assign activeValid    = r_vld;
  assign collisionHit   = r_hit;
  assign frameCollision = r_frame;

endmodule

// File: tb/tb_objects_mux_prio.sv
// Bench for objects_mux_prio: directed and random pixels, scoreboard queue of expected
// outputs fed by a per-pixel reference model, drained by an independent monitor.
module tb_objects_mux_prio;
  localparam int unsigned NL = 4;
  localparam int unsigned W  = 8;
  localparam int unsigned IW = 2;

  logic            clk = 1'b0;
  logic            resetN = 1'b0;
  logic            startOfFrame = 1'b0;
  logic [NL-1:0]   drawingRequest = '0;
  logic [NL*W-1:0] layerRGB = '0;
  logic [NL-1:0]   layerEnable = '1;
  logic [W-1:0]    backGroundRGB = '0;
  logic [W-1:0]    RGBOut;
  logic [IW-1:0]   activeLayer;
  logic            activeValid;
  logic [NL-1:0]   collisionHit;
  logic [NL-1:0]   frameCollision;

  objects_mux_prio #(
    .NUM_LAYERS        (NL),
    .RGB_W             (W),
    .TRANSPARENT_COLOR (8'hFF)
  ) dut (
    .clk            (clk),
    .resetN         (resetN),
    .startOfFrame   (startOfFrame),
    .drawingRequest (drawingRequest),
    .layerRGB       (layerRGB),
    .layerEnable    (layerEnable),
    .backGroundRGB  (backGroundRGB),
    .RGBOut         (RGBOut),
    .activeLayer    (activeLayer),
    .activeValid    (activeValid),
    .collisionHit   (collisionHit),
    .frameCollision (frameCollision)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]  rgb;
    logic [IW-1:0] idx;
    logic          vld;
    logic [NL-1:0] hit;
    logic [NL-1:0] frame;
  } exp_t;

  exp_t          sb[$];
  logic [NL-1:0] frame_acc = '0;
  logic [NL-1:0] frame_pub = '0;
  int            n_checks  = 0;
  int            n_fail    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // One pixel, sampled at the next rising edge; its expected results go to the scoreboard.
  task automatic cyc(input logic [NL-1:0] req, input logic [NL*W-1:0] rgb,
                     input logic [NL-1:0] en, input logic [W-1:0] bg, input logic sof);
    exp_t          e;
    logic [NL-1:0] qv;
    logic [W-1:0]  c;
    bit            found;
    @(negedge clk);
    resetN         = 1'b1;
    drawingRequest = req;
    layerRGB       = rgb;
    layerEnable    = en;
    backGroundRGB  = bg;
    startOfFrame   = sof;
    for (int k = 0; k < NL; k++) begin
      c     = rgb[k*W +: W];
      qv[k] = req[k] && en[k] && (c != 8'hFF);
    end
    e.rgb = bg;
    e.idx = '0;
    e.vld = 1'b0;
    found = 0;
    for (int k = 0; k < NL; k++) begin
      if (!found && qv[k]) begin
        found = 1;
        e.rgb = rgb[k*W +: W];
        e.idx = IW'(k);
        e.vld = 1'b1;
      end
    end
    e.hit = qv[0] ? {qv[NL-1:1], 1'b0} : '0;
    // A frame's collisions are the pixels sampled from its start pulse up to the next pulse.
    if (sof) begin
      frame_pub = frame_acc;
      frame_acc = e.hit;
    end else begin
      frame_acc = frame_acc | e.hit;
    end
    e.frame = frame_pub;
    sb.push_back(e);
  endtask

  task automatic rand_cyc();
    logic [NL*W-1:0] rgb;
    logic [NL-1:0]   en;
    for (int k = 0; k < NL; k++)
      rgb[k*W +: W] = ($urandom_range(0, 3) == 0) ? 8'hFF : W'($urandom);
    en = ($urandom_range(0, 7) == 0) ? NL'($urandom) : '1;
    cyc(NL'($urandom), rgb, en, W'($urandom), $urandom_range(0, 15) == 0);
  endtask

  // Asserted away from any edge; release happens with the next pixel driven by cyc().
  task automatic do_reset(input int hold);
    @(negedge clk);
    #2;
    resetN = 1'b0;
    sb.delete();
    frame_acc = '0;
    frame_pub = '0;
    #1;
    chk("async_rst_rgb", 32'(RGBOut), 0);
    chk("async_rst_frame", 32'(frameCollision), 0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      drawingRequest = NL'($urandom);
      layerRGB       = (NL*W)'({$urandom, $urandom});
      backGroundRGB  = W'($urandom);
      startOfFrame   = 1'($urandom);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!resetN) begin
        chk("rst_rgb", 32'(RGBOut), 0);
        chk("rst_layer", 32'(activeLayer), 0);
        chk("rst_valid", 32'(activeValid), 0);
        chk("rst_hit", 32'(collisionHit), 0);
        chk("rst_frame", 32'(frameCollision), 0);
      end else if (sb.size() == 1) begin
        chk("post_rst_rgb", 32'(RGBOut), 0);
        chk("post_rst_valid", 32'(activeValid), 0);
        chk("post_rst_frame", 32'(frameCollision), 0);
      end else if (sb.size() >= 2) begin
        chk("frameCollision", 32'(frameCollision), 32'(sb[$].frame));
        e = sb.pop_front();
        chk("RGBOut", 32'(RGBOut), 32'(e.rgb));
        chk("activeLayer", 32'(activeLayer), 32'(e.idx));
        chk("activeValid", 32'(activeValid), 32'(e.vld));
        chk("collisionHit", 32'(collisionHit), 32'(e.hit));
      end
    end
  end

  initial begin : stim
    logic [NL*W-1:0] rgbs;
    logic [NL*W-1:0] rgbs_t;
    rgbs   = {8'h40, 8'h30, 8'h20, 8'h10};
    rgbs_t = {8'h40, 8'h30, 8'hFF, 8'h10};
    do_reset(4);

    // Priority and background
    cyc(4'b0110, rgbs, 4'hF, 8'h05, 1'b0);
    cyc(4'b0000, rgbs, 4'hF, 8'h05, 1'b0);
    // Transparency, then enable mask
    cyc(4'b1110, rgbs_t, 4'hF, 8'h05, 1'b0);
    cyc(4'b1110, rgbs_t, 4'b1011, 8'h05, 1'b0);
    // Collision pulse for three pixels
    for (int i = 0; i < 3; i++) cyc(4'b1001, rgbs, 4'hF, 8'h05, 1'b0);
    cyc(4'b0000, rgbs, 4'hF, 8'h05, 1'b0);
    // Frame latch: A has a 0/2 overlap, B has none
    cyc(4'b0000, rgbs, 4'hF, 8'h05, 1'b1);
    cyc(4'b0101, rgbs, 4'hF, 8'h05, 1'b0);
    for (int i = 0; i < 3; i++) cyc(4'b0010, rgbs, 4'hF, 8'h05, 1'b0);
    cyc(4'b0000, rgbs, 4'hF, 8'h05, 1'b1);
    for (int i = 0; i < 5; i++) cyc(4'b0110, rgbs, 4'hF, 8'h05, 1'b0);
    cyc(4'b0000, rgbs, 4'hF, 8'h05, 1'b1);
    // Boundary: overlap just before the pulse, then overlap with the pulse
    cyc(4'b0011, rgbs, 4'hF, 8'h05, 1'b0);
    cyc(4'b0000, rgbs, 4'hF, 8'h05, 1'b1);
    cyc(4'b0011, rgbs, 4'hF, 8'h05, 1'b1);
    for (int i = 0; i < 3; i++) cyc(4'b0000, rgbs, 4'hF, 8'h05, 1'b0);
    cyc(4'b0000, rgbs, 4'hF, 8'h05, 1'b1);
    // Back-to-back pulses
    cyc(4'b1101, rgbs, 4'hF, 8'h05, 1'b1);
    cyc(4'b0000, rgbs, 4'hF, 8'h05, 1'b1);
    cyc(4'b0000, rgbs, 4'hF, 8'h05, 1'b1);

    for (int i = 0; i < 1500; i++) rand_cyc();
    do_reset(3);
    for (int i = 0; i < 1500; i++) rand_cyc();
    for (int i = 0; i < 3; i++) cyc(4'b0000, rgbs, 4'hF, 8'h05, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
